// File: rtl/seg_scan_decoder_if.sv
// Scanned 7-segment bus as seen by the decoder, plus the recovered digits
// and status flags. The bench drives through master; the decoder is slave.
interface seg_scan_decoder_if;
  logic        sample_en;
  logic [7:0]  seg_tube;
  logic [3:0]  seg_light;
  logic [15:0] digits;
  logic [3:0]  disagree;
  logic [3:0]  agree;
  logic        frame_valid;
  logic        digits_update;
  logic        code_err;
  logic        seq_err;
  logic        link_lost;

  modport master (
    output sample_en, seg_tube, seg_light,
    input  digits, disagree, agree, frame_valid, digits_update,
           code_err, seq_err, link_lost
  );

  modport slave (
    input  sample_en, seg_tube, seg_light,
    output digits, disagree, agree, frame_valid, digits_update,
           code_err, seq_err, link_lost
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four digits of a scanned, active-low 7-segment display.
// A frame is the scan 0001..1000 and completes when the select wraps back
// to 0001. Frames are qualified for scan order, legal codes and stability
// before being published on digits.
module seg_scan_decoder #(
  parameter int STABLE_FRAMES   = 2,
  parameter int TIMEOUT_SAMPLES = 16
) (
  input logic          clk,
  input logic          rst_n,
  seg_scan_decoder_if.slave bus
);
  typedef enum logic {ST_SYNC, ST_COLLECT} state_t;

  localparam logic [3:0] LP_STABLE  = 4'(STABLE_FRAMES);
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_SAMPLES);

  state_t          r_state, w_state_nxt;
  logic [3:0][3:0] r_slot;
  logic [3:0]      r_slot_ok;
  logic [3:0]      r_last_sel;
  logic [15:0]     r_prev;
  logic [15:0]     r_digits;
  logic [3:0]      r_stable;
  logic [7:0]      r_to;
  logic            r_fv, r_upd, r_cerr, r_serr, r_ll;

  logic [3:0] w_code;
  logic       w_code_ok;
  logic [1:0] w_idx;
  logic [3:0] w_exp_sel;
  logic [7:0] w_to_inc;
  logic       w_cap, w_clr_slots, w_seq_err, w_complete, w_timeout;
  logic       w_frame_ok, w_load;
  logic [3:0] w_stable_nxt;
  logic       w_unused_dp;

  // decimal point carries nothing for the decoder
  assign w_unused_dp = bus.seg_tube[7];
  assign w_exp_sel   = {r_last_sel[2:0], r_last_sel[3]};
  assign w_to_inc    = r_to + 8'd1;
  assign w_frame_ok  = &r_slot_ok;

  // segment pattern -> digit; anything else (blank included) is illegal
  always_comb begin
    w_code    = 4'hF;
    w_code_ok = 1'b1;
    case (bus.seg_tube[6:0])
      7'h40:   w_code = 4'd0;
      7'h79:   w_code = 4'd1;
      7'h24:   w_code = 4'd2;
      7'h30:   w_code = 4'd3;
      7'h19:   w_code = 4'd4;
      7'h12:   w_code = 4'd5;
      7'h02:   w_code = 4'd6;
      7'h78:   w_code = 4'd7;
      7'h00:   w_code = 4'd8;
      7'h10:   w_code = 4'd9;
      default: w_code_ok = 1'b0;
    endcase
  end

  // slot index of a one-hot select (only used when the select is one-hot)
  always_comb begin
    w_idx = 2'd0;
    case (bus.seg_light)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // scan-order tracking, frame completion and timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_clr_slots = 1'b0;
    w_seq_err   = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    if (bus.sample_en) begin
      case (r_state)
        ST_SYNC: begin
          if (bus.seg_light == 4'b0001) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (bus.seg_light == r_last_sel) begin
            w_cap = 1'b1;                 // oversampled digit
          end else if (bus.seg_light == w_exp_sel) begin
            w_cap      = 1'b1;
            w_complete = r_last_sel[3];   // 1000 -> 0001 closes the frame
          end else begin
            w_seq_err   = 1'b1;
            w_clr_slots = 1'b1;
            w_state_nxt = ST_SYNC;
            if (bus.seg_light == 4'b0001) begin
              w_cap       = 1'b1;
              w_state_nxt = ST_COLLECT;
            end
          end
        end
        default: w_state_nxt = ST_SYNC;
      endcase
      // a completing frame clears the counter, so it can never time out
      if (!w_complete && (w_to_inc >= LP_TIMEOUT)) begin
        w_timeout   = 1'b1;
        w_state_nxt = ST_SYNC;
      end
    end
  end

  // stability count for the frame being closed and the digits load decision
  always_comb begin
    if (r_slot == r_prev)
      w_stable_nxt = (r_stable >= LP_STABLE) ? LP_STABLE : r_stable + 4'd1;
    else
      w_stable_nxt = 4'd1;
    w_load = w_complete && w_frame_ok && (w_stable_nxt == LP_STABLE) &&
             (r_slot != r_digits);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_SYNC;
    else        r_state <= w_state_nxt;
  end

  // slot buffer: a resync drops all validity, then the capture may set one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot     <= '0;
      r_slot_ok  <= '0;
      r_last_sel <= '0;
    end else begin
      if (w_clr_slots) r_slot_ok <= '0;
      if (w_cap) begin
        r_slot[w_idx]    <= w_code;
        r_slot_ok[w_idx] <= w_code_ok;
        r_last_sel       <= bus.seg_light;
      end
    end
  end

  // frame qualification, timeout counter, published digits and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_digits <= '0;
      r_stable <= '0;
      r_to     <= '0;
      r_fv     <= 1'b0;
      r_upd    <= 1'b0;
      r_cerr   <= 1'b0;
      r_serr   <= 1'b0;
      r_ll     <= 1'b0;
    end else begin
      r_fv   <= w_complete;
      r_upd  <= w_load;
      r_cerr <= w_complete && !w_frame_ok;
      r_serr <= w_seq_err;
      if (bus.sample_en) r_to <= (w_complete || w_timeout) ? 8'd0 : w_to_inc;
      if (w_complete) begin
        r_prev   <= r_slot;
        r_ll     <= 1'b0;
        r_stable <= w_frame_ok ? w_stable_nxt : 4'd0;
      end
      if (w_seq_err || w_timeout) r_stable <= 4'd0;
      if (w_timeout) r_ll <= 1'b1;
      if (w_load) r_digits <= r_slot;
    end
  end

  assign bus.digits        = r_digits;
  assign bus.disagree      = r_digits[3:0];
  assign bus.agree         = r_digits[11:8];
  assign bus.frame_valid   = r_fv;
  assign bus.digits_update = r_upd;
  assign bus.code_err      = r_cerr;
  assign bus.seq_err       = r_serr;
  assign bus.link_lost     = r_ll;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized bench for seg_scan_decoder against a sample-level reference
// model. Each sample's observed outputs are traced next to the model's
// prediction; every scenario task compares its own trace and key values.
module tb_seg_scan_decoder;
  localparam int ST = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if bus();
  seg_scan_decoder #(.STABLE_FRAMES(ST), .TIMEOUT_SAMPLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // reference model state
  bit          m_coll;
  int          m_last;
  int          m_slot [4];
  bit          m_ok [4];
  logic [15:0] m_prev, m_digits;
  int          m_stable, m_to;
  bit          m_ll;
  bit          e_fv, e_upd, e_cerr, e_serr;

  // trace entry: {digits, frame_valid, digits_update, code_err, seq_err, link_lost}
  logic [20:0] obs_q [$];
  logic [20:0] exp_q [$];

  function automatic int dec(input logic [7:0] s);
    for (int i = 0; i < 10; i++) if (s[6:0] == SEG[i][6:0]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] enc(input int d);
    logic [7:0] v;
    v = SEG[d];
    v[7] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [31:0] codes_of(input logic [15:0] val);
    logic [31:0] c;
    for (int s = 0; s < 4; s++) c[8*s +: 8] = enc(int'(val[4*s +: 4]));
    return c;
  endfunction

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int s = 0; s < 4; s++) v[4*s +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic model_reset();
    m_coll = 0; m_last = 0; m_prev = '0; m_digits = '0;
    m_stable = 0; m_to = 0; m_ll = 0;
    e_fv = 0; e_upd = 0; e_cerr = 0; e_serr = 0;
    for (int i = 0; i < 4; i++) begin m_slot[i] = 0; m_ok[i] = 0; end
  endtask

  task automatic model_put(input int idx, input int d);
    m_slot[idx] = (d < 0) ? 15 : d;
    m_ok[idx]   = (d >= 0);
  endtask

  task automatic model_step(input logic [3:0] sel, input logic [7:0] seg);
    int idx, d;
    logic [15:0] frame;
    bit all_ok, complete;
    e_fv = 0; e_upd = 0; e_cerr = 0; e_serr = 0; complete = 0;
    idx = ($countones(sel) != 1) ? -1 : sel[0] ? 0 : sel[1] ? 1 : sel[2] ? 2 : 3;
    d = dec(seg);
    frame  = {4'(m_slot[3]), 4'(m_slot[2]), 4'(m_slot[1]), 4'(m_slot[0])};
    all_ok = m_ok[0] && m_ok[1] && m_ok[2] && m_ok[3];
    m_to++;
    if (!m_coll) begin
      if (idx == 0) begin m_coll = 1; m_last = 0; model_put(0, d); end
    end else if (idx == m_last) begin
      model_put(idx, d);
    end else if (idx >= 0 && idx == (m_last + 1) % 4) begin
      complete = (m_last == 3);
      model_put(idx, d);
      m_last = idx;
    end else begin
      e_serr = 1; m_stable = 0; m_coll = 0;
      for (int i = 0; i < 4; i++) m_ok[i] = 0;
      if (idx == 0) begin m_coll = 1; m_last = 0; model_put(0, d); end
    end
    if (complete) begin
      m_to = 0; e_fv = 1; m_ll = 0;
      if (!all_ok) begin
        e_cerr = 1; m_stable = 0;
      end else begin
        m_stable = (frame == m_prev) ? ((m_stable < ST) ? m_stable + 1 : ST) : 1;
        if (m_stable == ST && frame != m_digits) begin m_digits = frame; e_upd = 1; end
      end
      m_prev = frame;
    end else if (m_to >= TO) begin
      m_ll = 1; m_coll = 0; m_stable = 0; m_to = 0;
    end
  endtask

  // one clock of stimulus; the sample is taken at the next rising edge
  task automatic smp(input logic [3:0] sel, input logic [7:0] seg, input bit en);
    bus.sample_en = en; bus.seg_light = sel; bus.seg_tube = seg;
    @(posedge clk); #1;
    if (en) model_step(sel, seg);
    else begin e_fv = 0; e_upd = 0; e_cerr = 0; e_serr = 0; end
    obs_q.push_back({bus.digits, bus.frame_valid, bus.digits_update,
                     bus.code_err, bus.seq_err, bus.link_lost});
    exp_q.push_back({m_digits, e_fv, e_upd, e_cerr, e_serr, m_ll});
  endtask

  task automatic scan(input logic [31:0] codes, input int os);
    for (int s = 0; s < 4; s++) repeat (os) smp(4'(1 << s), codes[8*s +: 8], 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.sample_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.sample_en = 1'b0; bus.seg_light = 4'h0; bus.seg_tube = 8'hFF;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    n_tests++; if (bus.digits !== 16'h0) begin n_fail++; $display("FAIL reset_digits got %h exp 0000", bus.digits); end
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b exp 0", bus.frame_valid); end
    n_tests++; if (bus.digits_update !== 1'b0) begin n_fail++; $display("FAIL reset_upd got %b exp 0", bus.digits_update); end
    n_tests++; if (bus.code_err !== 1'b0 || bus.seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b exp 00", bus.code_err, bus.seq_err); end
    n_tests++; if (bus.link_lost !== 1'b0) begin n_fail++; $display("FAIL reset_ll got %b exp 0", bus.link_lost); end
  endtask

  task automatic test_clean_scan();
    int n_fv, n_upd;
    do_reset();
    obs_q.delete(); exp_q.delete();
    repeat (3) scan(codes_of(16'h0105), 1);
    smp(4'b0001, enc(5), 1'b1);
    n_fv = 0; n_upd = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_fv += int'(obs_q[i][4]); n_upd += int'(obs_q[i][3]);
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL clean_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (n_fv != 3) begin n_fail++; $display("FAIL clean_fv_count got %0d exp 3", n_fv); end
    n_tests++; if (n_upd != 1) begin n_fail++; $display("FAIL clean_upd_count got %0d exp 1", n_upd); end
    n_tests++; if (!obs_q[8][3]) begin n_fail++; $display("FAIL clean_upd_on_frame2 got %b exp 1", obs_q[8][3]); end
    n_tests++; if (bus.digits !== 16'h0105) begin n_fail++; $display("FAIL clean_digits got %h exp 0105", bus.digits); end
    n_tests++; if (bus.disagree !== 4'd5) begin n_fail++; $display("FAIL clean_disagree got %0d exp 5", bus.disagree); end
    n_tests++; if (bus.agree !== 4'd1) begin n_fail++; $display("FAIL clean_agree got %0d exp 1", bus.agree); end
  endtask

  task automatic test_oversample();
    int n_fv, n_upd, n_serr;
    do_reset();
    obs_q.delete(); exp_q.delete();
    repeat (3) scan(codes_of(16'h0105), 3);
    smp(4'b0001, enc(5), 1'b1);
    n_fv = 0; n_upd = 0; n_serr = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_fv += int'(obs_q[i][4]); n_upd += int'(obs_q[i][3]); n_serr += int'(obs_q[i][1]);
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL over_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (n_fv != 3 || n_upd != 1) begin n_fail++; $display("FAIL over_counts got fv=%0d upd=%0d exp fv=3 upd=1", n_fv, n_upd); end
    n_tests++; if (n_serr != 0) begin n_fail++; $display("FAIL over_seq_err got %0d exp 0", n_serr); end
    n_tests++; if (bus.digits !== 16'h0105) begin n_fail++; $display("FAIL over_digits got %h exp 0105", bus.digits); end
  endtask

  task automatic test_out_of_order();
    int n_serr;
    logic [15:0] held;
    obs_q.delete(); exp_q.delete();
    smp(4'b0001, enc(5), 1'b1);
    smp(4'b0100, enc(1), 1'b1);
    smp(4'b0100, enc(1), 1'b0);
    held = bus.digits;
    n_serr = 0;
    for (int i = 0; i < obs_q.size(); i++) n_serr += int'(obs_q[i][1]);
    n_tests++; if (n_serr != 1) begin n_fail++; $display("FAIL ooo_seq_err_count got %0d exp 1", n_serr); end
    n_tests++; if (held !== 16'h0105) begin n_fail++; $display("FAIL ooo_digits_held got %h exp 0105", held); end
    repeat (2) scan(codes_of(16'h2384), 1);
    smp(4'b0001, enc(4), 1'b1);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ooo_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (bus.digits !== 16'h2384 || bus.digits_update !== 1'b1) begin n_fail++; $display("FAIL ooo_recover got %h/%b exp 2384/1", bus.digits, bus.digits_update); end
  endtask

  task automatic test_illegal_code();
    logic [31:0] bad;
    int n_cerr, n_co;
    obs_q.delete(); exp_q.delete();
    bad = codes_of(16'h2384);
    bad[23:16] = 8'h7F;
    scan(bad, 1);
    scan(codes_of(16'h9876), 1);
    n_tests++; if (bus.digits !== 16'h2384) begin n_fail++; $display("FAIL ill_digits_held got %h exp 2384", bus.digits); end
    scan(codes_of(16'h9876), 1);
    smp(4'b0001, enc(6), 1'b1);
    n_cerr = 0; n_co = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cerr += int'(obs_q[i][2]); n_co += int'(obs_q[i][2] && obs_q[i][4]);
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ill_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (n_cerr != 1 || n_co != 1) begin n_fail++; $display("FAIL ill_code_err got %0d with_fv=%0d exp 1/1", n_cerr, n_co); end
    n_tests++; if (bus.digits !== 16'h9876) begin n_fail++; $display("FAIL ill_digits got %h exp 9876", bus.digits); end
  endtask

  task automatic test_timeout();
    logic ll15;
    obs_q.delete(); exp_q.delete();
    repeat (TO - 1) smp(4'b0000, 8'hFF, 1'b1);
    ll15 = bus.link_lost;
    smp(4'b0000, 8'hFF, 1'b1);
    n_tests++; if (ll15 !== 1'b0) begin n_fail++; $display("FAIL to_early got %b exp 0", ll15); end
    n_tests++; if (bus.link_lost !== 1'b1) begin n_fail++; $display("FAIL to_set got %b exp 1", bus.link_lost); end
    n_tests++; if (bus.digits !== 16'h9876) begin n_fail++; $display("FAIL to_digits_held got %h exp 9876", bus.digits); end
    scan(codes_of(16'h0105), 1);
    n_tests++; if (bus.link_lost !== 1'b1) begin n_fail++; $display("FAIL to_hold got %b exp 1", bus.link_lost); end
    smp(4'b0001, enc(5), 1'b1);
    n_tests++; if (bus.link_lost !== 1'b0 || bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL to_clear got ll=%b fv=%b exp ll=0 fv=1", bus.link_lost, bus.frame_valid); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL to_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_collect();
    int n_fv, n_upd;
    obs_q.delete(); exp_q.delete();
    smp(4'b0010, enc(0), 1'b1);
    bus.sample_en = 1'b1; bus.seg_light = 4'b0100; bus.seg_tube = 8'hF9;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    n_tests++; if (bus.digits !== 16'h0) begin n_fail++; $display("FAIL rmid_digits got %h exp 0000", bus.digits); end
    n_tests++; if ({bus.frame_valid, bus.digits_update, bus.code_err, bus.seq_err, bus.link_lost} !== 5'b0) begin
      n_fail++; $display("FAIL rmid_pulses got %b exp 00000", {bus.frame_valid, bus.digits_update, bus.code_err, bus.seq_err, bus.link_lost}); end
    obs_q.delete(); exp_q.delete();
    scan(codes_of(16'h4321), 1);
    smp(4'b0001, enc(1), 1'b1);
    n_tests++; if (bus.frame_valid !== 1'b1 || bus.digits_update !== 1'b0) begin n_fail++; $display("FAIL rmid_first got fv=%b upd=%b exp 1/0", bus.frame_valid, bus.digits_update); end
    scan(codes_of(16'h4321), 1);
    smp(4'b0001, enc(1), 1'b1);
    n_fv = 0; n_upd = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_fv += int'(obs_q[i][4]); n_upd += int'(obs_q[i][3]);
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (n_fv != 2 || n_upd != 1 || bus.digits !== 16'h4321) begin n_fail++; $display("FAIL rmid_second got fv=%0d upd=%0d d=%h exp 2/1/4321", n_fv, n_upd, bus.digits); end
  endtask

  task automatic test_random();
    logic [15:0] pool [3];
    logic [15:0] cur;
    logic [7:0]  sg;
    int g, r;
    do_reset();
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) pool[i] = rand_val();
    cur = pool[0]; g = 0;
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        repeat (TO + 1) smp(4'b0000, 8'($urandom), 1'b1);
      end else if (r < 8) begin
        smp(4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
      end else if (r < 18) begin
        smp(4'($urandom_range(0, 15)), 8'($urandom), 1'b0);
      end else begin
        if (r >= 45) begin
          g = (g + 1) % 4;
          if (g == 0) cur = pool[$urandom_range(0, 2)];
        end
        sg = ($urandom_range(0, 99) < 4) ? 8'($urandom) : enc(int'(cur[4*g +: 4]));
        smp(4'(1 << g), sg, 1'b1);
      end
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_trace[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    bus.sample_en = 1'b0; bus.seg_light = 4'h0; bus.seg_tube = 8'hFF;
    test_reset();
    test_clean_scan();
    test_oversample();
    test_out_of_order();
    test_illegal_code();
    test_timeout();
    test_reset_mid_collect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
